// File: rtl/fb_axi_pkg.sv
// Shared encodings for the framebuffer AXI4 slave: burst types, response
// codes and the read/write channel FSM state types.
package fb_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/fb_axi_burst_addr.sv
// Combinational next-beat address for an AXI burst. FIXED holds the
// address; INCR, WRAP (treated as INCR) and the reserved encoding step by
// 1<<size. The 32-bit sum wraps modulo 2^32.
module fb_axi_burst_addr
  import fb_axi_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_next
);

  // Step the address by the beat size unless the burst is FIXED.
  always_comb begin
    o_next = i_addr;
    case (i_burst)
      BURST_FIXED:             o_next = i_addr;
      BURST_INCR, BURST_WRAP:  o_next = i_addr + (32'd1 << i_size);
      default:                 o_next = i_addr + (32'd1 << i_size);
    endcase
  end

endmodule

// File: rtl/fb_axi_slave.sv
// AXI4 slave framebuffer: 2^MEM_AW x 64-bit memory with independent read
// and write channel FSMs. The read side streams one beat per cycle so a
// 200-beat scanline burst finishes in 201 cycles from the AR handshake.
// Optional macro FB_AXI_RANGE_CHECK_EN: out-of-window beats are dropped
// (writes) or return zero (reads) with SLVERR; otherwise addresses alias.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both 1; a source holds its payload stable
// while valid is 1 and ready is 0, and never withdraws valid unaccepted.
module fb_axi_slave
  import fb_axi_pkg::*;
#(
  parameter int          MEM_AW = 18,
  parameter logic [31:0] BASE   = 32'h0
)
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [63:0] io_slave_wdata,
  input  logic [7:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [63:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  logic [63:0] r_mem [0:(1<<MEM_AW)-1];

  // Write channel state
  w_state_t    r_wstate;
  logic        r_awready, r_wready, r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic [7:0]  r_wlen;
  logic [8:0]  r_wcnt;
  logic        r_werr;

  // Read channel state
  r_state_t    r_rstate;
  logic        r_arready, r_rvalid, r_rlast;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rleft;

  logic [31:0]       w_wnext, w_woff, w_rcur_addr, w_rnext, w_roff;
  logic [2:0]        w_rcur_size;
  logic [1:0]        w_rcur_burst;
  logic [MEM_AW-1:0] w_widx, w_ridx;
  logic              w_wbeat, w_wen, w_woor, w_wlen_bad;
  logic              w_rload_idle, w_rload_data, w_rload, w_roor;
  logic              w_unused_bits;

`ifdef FB_AXI_RANGE_CHECK_EN
  // Out of range when below BASE or at/after BASE + 8*2^MEM_AW.
  function automatic logic f_oor(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return off[32] || (off[31:MEM_AW+3] != '0);
  endfunction
  assign w_woor = f_oor(r_waddr);
  assign w_roor = f_oor(w_rcur_addr);
`else
  assign w_woor = 1'b0;
  assign w_roor = 1'b0;
`endif

  assign w_woff     = r_waddr - BASE;
  assign w_widx     = w_woff[MEM_AW+2:3];
  assign w_wbeat    = (r_wstate == W_DATA) && io_slave_wvalid;
  assign w_wen      = w_wbeat && !w_woor;
  assign w_wlen_bad = (r_wcnt != {1'b0, r_wlen});

  // The first read beat is fetched in the AR handshake cycle itself, so the
  // address source switches between the AR channel and the burst register.
  assign w_rcur_addr  = (r_rstate == R_IDLE) ? io_slave_araddr  : r_raddr;
  assign w_rcur_size  = (r_rstate == R_IDLE) ? io_slave_arsize  : r_rsize;
  assign w_rcur_burst = (r_rstate == R_IDLE) ? io_slave_arburst : r_rburst;
  assign w_roff       = w_rcur_addr - BASE;
  assign w_ridx       = w_roff[MEM_AW+2:3];
  assign w_rload_idle = (r_rstate == R_IDLE) && io_slave_arvalid;
  assign w_rload_data = (r_rstate == R_DATA) && (!r_rvalid || io_slave_rready)
                        && (r_rleft != 8'd0);
  assign w_rload      = w_rload_idle || w_rload_data;

  // Offset bits outside the word index are deliberately ignored.
  assign w_unused_bits = &{1'b0, w_woff, w_roff};

  fb_axi_burst_addr u_waddr_step (
    .i_addr  (r_waddr),
    .i_size  (r_wsize),
    .i_burst (r_wburst),
    .o_next  (w_wnext)
  );

  fb_axi_burst_addr u_raddr_step (
    .i_addr  (w_rcur_addr),
    .i_size  (w_rcur_size),
    .i_burst (w_rcur_burst),
    .o_next  (w_rnext)
  );

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_wen) begin
      for (int b = 0; b < 8; b++) begin
        if (io_slave_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= io_slave_wdata[b*8 +: 8];
      end
    end
  end

  // Write FSM: accept address, absorb beats until wlast, then hold response.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= 4'd0;
      r_waddr   <= 32'd0;
      r_wsize   <= 3'd0;
      r_wburst  <= BURST_FIXED;
      r_wlen    <= 8'd0;
      r_wcnt    <= 9'd0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (io_slave_awvalid) begin
            r_waddr   <= io_slave_awaddr;
            r_bid     <= io_slave_awid;
            r_wlen    <= io_slave_awlen;
            r_wsize   <= io_slave_awsize;
            r_wburst  <= io_slave_awburst;
            r_wcnt    <= 9'd0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= w_wnext;
            r_wcnt  <= r_wcnt + 9'd1;
            r_werr  <= r_werr | w_woor;
            if (io_slave_wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (w_wlen_bad || r_werr || w_woor) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (io_slave_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: registered output stage refilled whenever it is empty or drained.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= 64'd0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= 4'd0;
      r_raddr   <= 32'd0;
      r_rsize   <= 3'd0;
      r_rburst  <= BURST_FIXED;
      r_rleft   <= 8'd0;
    end else begin
      if (w_rload) begin
        r_rdata  <= w_roor ? 64'd0 : r_mem[w_ridx];
        r_rresp  <= w_roor ? RESP_SLVERR : RESP_OKAY;
        r_rvalid <= 1'b1;
        r_raddr  <= w_rnext;
      end
      case (r_rstate)
        R_IDLE: begin
          if (io_slave_arvalid) begin
            r_rid     <= io_slave_arid;
            r_rsize   <= io_slave_arsize;
            r_rburst  <= io_slave_arburst;
            r_rleft   <= io_slave_arlen;
            r_rlast   <= (io_slave_arlen == 8'd0);
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rload_data) begin
            r_rleft <= r_rleft - 8'd1;
            r_rlast <= (r_rleft == 8'd1);
          end else if (r_rvalid && io_slave_rready && (r_rleft == 8'd0)) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign io_slave_awready = r_awready;
  assign io_slave_wready  = r_wready;
  assign io_slave_bvalid  = r_bvalid;
  assign io_slave_bresp   = r_bresp;
  assign io_slave_bid     = r_bid;
  assign io_slave_arready = r_arready;
  assign io_slave_rvalid  = r_rvalid;
  assign io_slave_rdata   = r_rdata;
  assign io_slave_rresp   = r_rresp;
  assign io_slave_rlast   = r_rlast;
  assign io_slave_rid     = r_rid;

endmodule

// File: tb/tb_fb_axi_slave.sv
// Self-checking bench for fb_axi_slave: table of single-word write/read
// vectors, then hand-written burst, backpressure, wlast-error and
// mid-burst reset sequences. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fb_axi_slave;
  import fb_axi_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        io_slave_awvalid = 1'b0, io_slave_awready;
  logic [31:0] io_slave_awaddr = '0;
  logic [3:0]  io_slave_awid = '0;
  logic [7:0]  io_slave_awlen = '0;
  logic [2:0]  io_slave_awsize = 3'd3;
  logic [1:0]  io_slave_awburst = BURST_INCR;
  logic        io_slave_wvalid = 1'b0, io_slave_wready;
  logic [63:0] io_slave_wdata = '0;
  logic [7:0]  io_slave_wstrb = '0;
  logic        io_slave_wlast = 1'b0;
  logic        io_slave_bvalid, io_slave_bready = 1'b0;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;
  logic        io_slave_arvalid = 1'b0, io_slave_arready;
  logic [31:0] io_slave_araddr = '0;
  logic [3:0]  io_slave_arid = '0;
  logic [7:0]  io_slave_arlen = '0;
  logic [2:0]  io_slave_arsize = 3'd3;
  logic [1:0]  io_slave_arburst = BURST_INCR;
  logic        io_slave_rvalid, io_slave_rready = 1'b0;
  logic [63:0] io_slave_rdata;
  logic [1:0]  io_slave_rresp;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  fb_axi_slave dut (
    .clock(clock), .resetn(resetn),
    .io_slave_awvalid(io_slave_awvalid), .io_slave_awready(io_slave_awready),
    .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid),
    .io_slave_awlen(io_slave_awlen), .io_slave_awsize(io_slave_awsize),
    .io_slave_awburst(io_slave_awburst),
    .io_slave_wvalid(io_slave_wvalid), .io_slave_wready(io_slave_wready),
    .io_slave_wdata(io_slave_wdata), .io_slave_wstrb(io_slave_wstrb),
    .io_slave_wlast(io_slave_wlast),
    .io_slave_bvalid(io_slave_bvalid), .io_slave_bready(io_slave_bready),
    .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
    .io_slave_arvalid(io_slave_arvalid), .io_slave_arready(io_slave_arready),
    .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
    .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
    .io_slave_arburst(io_slave_arburst),
    .io_slave_rvalid(io_slave_rvalid), .io_slave_rready(io_slave_rready),
    .io_slave_rdata(io_slave_rdata), .io_slave_rresp(io_slave_rresp),
    .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rd_q[$];
  logic        rl_q[$];
  logic [1:0]  rr_q[$];
  logic        rd_first;
  logic [3:0]  rd_id;
  int          rd_cycles;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  int          wr_bwait;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: handshake wait expired, required within bound", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int nbeats, input logic [63:0] d0, input logic [7:0] strb,
                           input int bdelay);
    int t;
    io_slave_awaddr = addr; io_slave_awid = id; io_slave_awlen = len;
    io_slave_awsize = 3'd3; io_slave_awburst = BURST_INCR; io_slave_awvalid = 1'b1;
    t = 0;
    while (!io_slave_awready && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) fail_now("aw_wait");
    @(negedge clock);
    io_slave_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      io_slave_wvalid = 1'b1; io_slave_wdata = d0 + 64'(i);
      io_slave_wstrb = strb; io_slave_wlast = (i == nbeats - 1);
      t = 0;
      while (!io_slave_wready && t < 50) begin @(negedge clock); t++; end
      if (t >= 50) fail_now("w_wait");
      @(negedge clock);
    end
    io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      check("awready_during_resp", {63'd0, io_slave_awready}, 64'd0);
      check("bvalid_held", {63'd0, io_slave_bvalid}, 64'd1);
      @(negedge clock);
    end
    io_slave_bready = 1'b1;
    t = 0;
    while (!io_slave_bvalid && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) fail_now("b_wait");
    wr_bwait = t; wr_resp = io_slave_bresp; wr_bid = io_slave_bid;
    @(negedge clock);
    io_slave_bready = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int mode);
    int t, cyc;
    logic done, stalled, sl;
    logic [63:0] sd;
    rd_q.delete(); rl_q.delete(); rr_q.delete();
    io_slave_araddr = addr; io_slave_arid = id; io_slave_arlen = len;
    io_slave_arsize = 3'd3; io_slave_arburst = BURST_INCR; io_slave_arvalid = 1'b1;
    t = 0;
    while (!io_slave_arready && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) fail_now("ar_wait");
    @(negedge clock);
    io_slave_arvalid = 1'b0;
    rd_first = io_slave_rvalid; rd_id = io_slave_rid;
    cyc = 1; done = 1'b0; stalled = 1'b0; sd = '0; sl = 1'b0;
    while (!done && cyc < 2000) begin
      io_slave_rready = (mode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
      if (stalled) begin
        check("rdata_stable", io_slave_rdata, sd);
        check("rlast_stable", {63'd0, io_slave_rlast}, {63'd0, sl});
      end
      if (io_slave_rvalid && io_slave_rready) begin
        rd_q.push_back(io_slave_rdata); rl_q.push_back(io_slave_rlast);
        rr_q.push_back(io_slave_rresp);
        if (io_slave_rlast) done = 1'b1;
      end
      stalled = io_slave_rvalid && !io_slave_rready;
      sd = io_slave_rdata; sl = io_slave_rlast;
      @(negedge clock);
      cyc++;
    end
    if (!done) fail_now("r_last_wait");
    io_slave_rready = 1'b0;
    rd_cycles = cyc;
  endtask

  task automatic check_burst(input string name, input int n);
    logic [63:0] e;
    check({name, "_count"}, 64'(rd_q.size()), 64'(n));
    if (rd_q.size() == n) begin
      for (int k = 0; k < n; k++) begin
        e = exp_q.pop_front();
        check({name, "_data"}, rd_q[k], e);
        check({name, "_rlast"}, {63'd0, rl_q[k]}, {63'd0, (k == n - 1)});
        check({name, "_rresp"}, {62'd0, rr_q[k]}, {62'd0, RESP_OKAY});
      end
    end
    exp_q.delete();
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #1_000_000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[5];
    int   beats;
    vecs[0] = '{32'h0000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{32'h0000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{32'h0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'hFFFF_FFFF_0000_0000};
    vecs[3] = '{32'h0000_0018, 64'h1122_3344_5566_7788, 8'h81, 64'h1100_0000_0000_0088};
    vecs[4] = '{32'h001F_FFF8, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF, 64'hA5A5_5A5A_C3C3_3C3C};

    repeat (3) @(negedge clock);
    // Reset values while resetn is low
    check("rst_awready", {63'd0, io_slave_awready}, 64'd1);
    check("rst_arready", {63'd0, io_slave_arready}, 64'd1);
    check("rst_wready",  {63'd0, io_slave_wready},  64'd0);
    check("rst_bvalid",  {63'd0, io_slave_bvalid},  64'd0);
    check("rst_rvalid",  {63'd0, io_slave_rvalid},  64'd0);
    check("rst_rlast",   {63'd0, io_slave_rlast},   64'd0);
    check("rst_rdata",   io_slave_rdata,            64'd0);
    check("rst_bresp",   {62'd0, io_slave_bresp},   64'd0);
    check("rst_rresp",   {62'd0, io_slave_rresp},   64'd0);
    check("rst_bid",     {60'd0, io_slave_bid},     64'd0);
    check("rst_rid",     {60'd0, io_slave_rid},     64'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Table: clear word, strobed write, single-beat read back
    for (int i = 0; i < 5; i++) begin
      axi_write(vecs[i].addr, 4'(i), 8'd0, 1, 64'd0, 8'hFF, 0);
      axi_write(vecs[i].addr, 4'(i + 1), 8'd0, 1, vecs[i].wdata, vecs[i].strb, 0);
      check("vec_bresp", {62'd0, wr_resp}, {62'd0, RESP_OKAY});
      check("vec_bid", {60'd0, wr_bid}, 64'(i + 1));
      check("vec_b_latency", 64'(wr_bwait), 64'd0);
      axi_read(vecs[i].addr, 4'(i + 2), 8'd0, 0);
      check("vec_rvalid_next_cycle", {63'd0, rd_first}, 64'd1);
      check("vec_rid", {60'd0, rd_id}, 64'(i + 2));
      check("vec_read_cycles", 64'(rd_cycles), 64'd2);
      exp_q.push_back(vecs[i].exp);
      check_burst("vec", 1);
    end

    // 200-beat INCR write then arlen=199 read at full rate
    axi_write(32'h0000_1000, 4'h3, 8'd199, 200, 64'd0, 8'hFF, 0);
    check("burst_bresp", {62'd0, wr_resp}, {62'd0, RESP_OKAY});
    axi_read(32'h0000_1000, 4'h5, 8'd199, 0);
    check("burst_rvalid_next_cycle", {63'd0, rd_first}, 64'd1);
    check("burst_cycles", 64'(rd_cycles), 64'd201);
    for (int k = 0; k < 200; k++) exp_q.push_back(64'(k));
    check_burst("burst", 200);

    // 4-beat read under rready backpressure
    axi_read(32'h0000_1000, 4'h6, 8'd3, 1);
    check("bp_rid", {60'd0, rd_id}, 64'h6);
    for (int k = 0; k < 4; k++) exp_q.push_back(64'(k));
    check_burst("bp", 4);

    // Early wlast: awlen=3, only 2 beats sent over pre-filled words
    axi_write(32'h0000_2000, 4'h1, 8'd3, 4, 64'hEE00, 8'hFF, 0);
    check("fill_bresp", {62'd0, wr_resp}, {62'd0, RESP_OKAY});
    axi_write(32'h0000_2000, 4'hA, 8'd3, 2, 64'h50, 8'hFF, 3);
    check("early_bresp", {62'd0, wr_resp}, {62'd0, RESP_SLVERR});
    check("early_bid", {60'd0, wr_bid}, 64'hA);
    check("early_awready_back", {63'd0, io_slave_awready}, 64'd1);
    axi_read(32'h0000_2000, 4'h2, 8'd3, 0);
    exp_q.push_back(64'h50); exp_q.push_back(64'h51);
    exp_q.push_back(64'hEE02); exp_q.push_back(64'hEE03);
    check_burst("early", 4);

    // Late wlast: awlen=0 but 2 beats, both written
    axi_write(32'h0000_3000, 4'h4, 8'd0, 2, 64'h70, 8'hFF, 0);
    check("late_bresp", {62'd0, wr_resp}, {62'd0, RESP_SLVERR});
    axi_read(32'h0000_3000, 4'h4, 8'd1, 0);
    exp_q.push_back(64'h70); exp_q.push_back(64'h71);
    check_burst("late", 2);

    // Reset in the middle of a 200-beat read, at beat 50
    io_slave_araddr = 32'h0000_1000; io_slave_arid = 4'h7; io_slave_arlen = 8'd199;
    io_slave_arvalid = 1'b1;
    @(negedge clock);
    io_slave_arvalid = 1'b0;
    io_slave_rready = 1'b1;
    beats = 0;
    while (beats < 50) begin
      if (io_slave_rvalid) beats++;
      @(negedge clock);
    end
    check("midrst_busy_before", {63'd0, io_slave_rvalid}, 64'd1);
    resetn = 1'b0;
    #1;
    check("midrst_rvalid_async", {63'd0, io_slave_rvalid}, 64'd0);
    check("midrst_arready_async", {63'd0, io_slave_arready}, 64'd1);
    io_slave_rready = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("postrst_rvalid", {63'd0, io_slave_rvalid}, 64'd0);
    check("postrst_arready", {63'd0, io_slave_arready}, 64'd1);
    check("postrst_awready", {63'd0, io_slave_awready}, 64'd1);
    axi_read(32'h0000_1028, 4'h8, 8'd0, 0);
    exp_q.push_back(64'd5);
    check_burst("postrst_read", 1);
    axi_read(32'h0000_0000, 4'h9, 8'd0, 0);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    check_burst("postrst_persist", 1);

`ifdef FB_AXI_RANGE_CHECK_EN
    // First byte past the window: SLVERR and zero data
    axi_read(32'h0020_0000, 4'hB, 8'd0, 0);
    check("oor_count", 64'(rd_q.size()), 64'd1);
    if (rd_q.size() == 1) begin
      check("oor_rdata", rd_q[0], 64'd0);
      check("oor_rresp", {62'd0, rr_q[0]}, {62'd0, RESP_SLVERR});
    end
    axi_write(32'h0020_0000, 4'hC, 8'd0, 1, 64'hDEAD, 8'hFF, 0);
    check("oor_bresp", {62'd0, wr_resp}, {62'd0, RESP_SLVERR});
    axi_read(32'h0000_0000, 4'hD, 8'd0, 0);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    check_burst("oor_no_alias", 1);
`else
    // Without the check, 2 MiB past BASE aliases word 0
    axi_read(32'h0020_0000, 4'hB, 8'd0, 0);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    check_burst("alias", 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
